// File: rtl/lcd_write_arbiter.sv
// Round-robin arbiter sharing the LCD write engine between two requesters.
// Holds the bus for the HD44780 execution time before acknowledging.
module lcd_write_arbiter #(
  parameter int SHORT_WAIT = 2000,
  parameter int LONG_WAIT  = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       rs0,
  input  logic       rs1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       ack0,
  output logic       ack1,
  output logic       wr_enable,
  output logic       reg_sel,
  output logic [7:0] db_out,
  input  logic       wr_finish,
  output logic [1:0] grant,
  output logic       busy
);

  localparam int CW = (LONG_WAIT > 1) ? $clog2(LONG_WAIT) : 1;
  localparam logic [CW-1:0] SHORT_LD = CW'(SHORT_WAIT - 1);
  localparam logic [CW-1:0] LONG_LD  = CW'(LONG_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_WR,
    SETTLE,
    ACK
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last_served;
  logic          pick1;
  logic          long_cmd;

  // last_served == 1 means requester 1 went last, so req0 wins a tie
  assign pick1 = req1 & (~req0 | ~last_served);

  // clear (0x01) and return home (0x02/0x03) need the long settle time
  assign long_cmd = ~reg_sel & (db_out[7:2] == 6'd0)
                  & (db_out[1:0] != 2'd0);

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      last_served <= 1'b1;
      wr_enable   <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      grant       <= 2'b00;
      reg_sel     <= 1'b0;
      db_out      <= 8'h00;
    end else begin
      wr_enable <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req0 | req1) begin
            grant     <= pick1 ? 2'b10 : 2'b01;
            reg_sel   <= pick1 ? rs1 : rs0;
            db_out    <= pick1 ? data1 : data0;
            wr_enable <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT_WR;
        end
        WAIT_WR: begin
          if (wr_finish) begin
            cnt   <= long_cmd ? LONG_LD : SHORT_LD;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            ack0  <= grant[0];
            ack1  <= grant[1];
            state <= ACK;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ACK: begin
          last_served <= grant[1];
          grant       <= 2'b00;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Randomized bench for lcd_write_arbiter against a transaction-level model.
// Engine model answers wr_finish three cycles after wr_enable.
module tb_lcd_write_arbiter;

  localparam int SW = 4;
  localparam int LW = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic       rs0 = 1'b0, rs1 = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       wr_finish = 1'b0;
  logic       ack0, ack1, wr_enable, reg_sel, busy;
  logic [7:0] db_out;
  logic [1:0] grant;

  int n_chk = 0;
  int n_err = 0;
  int last_m = 1;

  lcd_write_arbiter #(.SHORT_WAIT(SW), .LONG_WAIT(LW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .rs0(rs0), .rs1(rs1),
    .data0(data0), .data1(data1),
    .ack0(ack0), .ack1(ack1),
    .wr_enable(wr_enable), .reg_sel(reg_sel),
    .db_out(db_out), .wr_finish(wr_finish),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // mode: 0 plain, 1 spurious wr_finish, 2 drop req0 + change inputs,
  // 3 reset during settle
  task automatic txn(input bit r0, input bit r1,
                     input bit s0, input bit s1,
                     input logic [7:0] d0, input logic [7:0] d1,
                     input int mode);
    bit         win1;
    bit         e_rs;
    logic [7:0] e_db;
    int         w;
    int         got;
    win1 = r1 && (!r0 || last_m == 0);
    e_rs = win1 ? s1 : s0;
    e_db = win1 ? d1 : d0;
    w = (!e_rs && e_db < 8'd4 && e_db != 8'd0) ? LW : SW;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_grant", 32'(grant), 0);
    req0 = r0; req1 = r1;
    rs0 = s0; rs1 = s1;
    data0 = d0; data1 = d1;
    wr_finish = (mode == 1);
    tick();
    wr_finish = 1'b0;
    chk("wr_en", 32'(wr_enable), 1);
    chk("grant", 32'(grant), win1 ? 2 : 1);
    chk("reg_sel", 32'(reg_sel), 32'(e_rs));
    chk("db_out", 32'(db_out), 32'(e_db));
    chk("busy", 32'(busy), 1);
    tick();
    chk("wr_en_once", 32'(wr_enable), 0);
    if (mode == 2) req0 = 1'b0;
    tick();
    tick();
    wr_finish = 1'b1;
    got = 0;
    for (int i = 1; i <= w + 8 && got == 0; i++) begin
      tick();
      if (i == 1) wr_finish = 1'b0;
      if (mode == 1 && i == 2) wr_finish = 1'b1;
      if (mode == 1 && i == 3) wr_finish = 1'b0;
      if (mode == 2 && i == 2) begin
        data0 = ~data0; data1 = ~data1;
        rs0 = ~rs0; rs1 = ~rs1;
      end
      if (mode == 3 && i == 3) begin
        rst = 1'b0;
        #1;
        chk("rst_wr_en", 32'(wr_enable), 0);
        chk("rst_ack", {30'd0, ack1, ack0}, 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rs", 32'(reg_sel), 0);
        chk("rst_db", 32'(db_out), 0);
        req0 = 1'b0; req1 = 1'b0;
        repeat (w + 4) begin
          tick();
          chk("rst_noack", {30'd0, ack1, ack0}, 0);
        end
        rst = 1'b1;
        last_m = 1;
        tick();
        return;
      end
      if (ack0 | ack1) got = i;
    end
    chk("ack_lat", 32'(got), 32'(w + 1));
    chk("ack_who", {30'd0, ack1, ack0}, win1 ? 2 : 1);
    chk("hold_db", 32'(db_out), 32'(e_db));
    chk("hold_rs", 32'(reg_sel), 32'(e_rs));
    chk("hold_grant", 32'(grant), win1 ? 2 : 1);
    if (win1) req1 = 1'b0;
    else req0 = 1'b0;
    last_m = win1 ? 1 : 0;
    tick();
    chk("ack_once", {30'd0, ack1, ack0}, 0);
  endtask

  initial begin
    bit         r0, r1, s0, s1;
    logic [7:0] d0, d1;
    repeat (3) tick();
    chk("rst_wr_en0", 32'(wr_enable), 0);
    chk("rst_ack0", {30'd0, ack1, ack0}, 0);
    chk("rst_grant0", 32'(grant), 0);
    chk("rst_busy0", 32'(busy), 0);
    chk("rst_rs0", 32'(reg_sel), 0);
    chk("rst_db0", 32'(db_out), 0);
    rst = 1'b1;
    tick();

    txn(1, 0, 1, 0, 8'h41, 8'h00, 0);
    txn(0, 1, 0, 0, 8'h00, 8'h01, 0);
    txn(0, 1, 0, 0, 8'h00, 8'h02, 0);
    txn(0, 1, 0, 0, 8'h00, 8'h80, 0);
    txn(0, 1, 0, 1, 8'h00, 8'h01, 0);
    for (int i = 0; i < 4; i++)
      txn(1, 1, 1, 0, 8'h30 + 8'(i), 8'h03, 0);
    txn(1, 0, 0, 0, 8'h01, 8'h00, 1);
    txn(1, 0, 1, 0, 8'h55, 8'hAA, 2);
    txn(0, 1, 0, 0, 8'h00, 8'h01, 3);
    txn(1, 1, 1, 1, 8'h61, 8'h62, 0);

    for (int n = 0; n < 40; n++) begin
      r0 = 1'($urandom % 2);
      r1 = r0 ? 1'($urandom % 2) : 1'b1;
      s0 = 1'($urandom % 2);
      s1 = 1'($urandom % 2);
      d0 = ($urandom % 2 == 0) ? 8'($urandom % 4) : 8'($urandom);
      d1 = ($urandom % 2 == 0) ? 8'($urandom % 4) : 8'($urandom);
      txn(r0, r1, s0, s1, d0, d1, int'($urandom % 3));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
